// File: rtl/mac_ctrl_if.sv
// mac_ctrl_if: control/status bundle between a job issuer and mac_ctrl.
// master: job issuer side (start/len/stall). slave: the sequencer.
interface mac_ctrl_if #(
  parameter int unsigned LEN_W = 16
);
  logic             start;
  logic [LEN_W-1:0] len;
  logic             stall;
  logic             busy;
  logic             done;
  logic             start_err;
  logic             feed_req;
  logic             en_mult;
  logic             clr_mult;
  logic             en_accum;
  logic             clr_accum;
  logic             accum_start;
  logic [31:0]      perf_cycles;

  modport master (
    output start, len, stall,
    input  busy, done, start_err, feed_req, en_mult, clr_mult,
           en_accum, clr_accum, accum_start, perf_cycles
  );

  modport slave (
    input  start, len, stall,
    output busy, done, start_err, feed_req, en_mult, clr_mult,
           en_accum, clr_accum, accum_start, perf_cycles
  );
endinterface

// File: rtl/mac_ctrl.sv
// mac_ctrl: job sequencer for one multiply-accumulate processing element.
// Issues exactly K operand pairs, tracks them through a MULT_LAT-deep issue
// pipeline into the accumulator, drains MULT_LAT+ACC_LAT cycles, pulses done.
// Optional job cycle counter on perf_cycles: define MAC_CTRL_PERF_CNT_EN.
module mac_ctrl #(
  parameter int unsigned LEN_W    = 16,
  parameter int unsigned MULT_LAT = 1,
  parameter int unsigned ACC_LAT  = 1
) (
  input  logic        clk,
  input  logic        rst,
  mac_ctrl_if.slave   bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_FEED  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int unsigned      DRAIN_N    = MULT_LAT + ACC_LAT;
  localparam logic [LEN_W-1:0] DRAIN_LAST = LEN_W'(DRAIN_N - 1);
  localparam logic [LEN_W-1:0] ONE        = LEN_W'(1);

  logic [2:0]          state;
  logic [2:0]          state_nx;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    issue_cnt;
  logic [LEN_W-1:0]    drain_cnt;
  logic [MULT_LAT-1:0] pipe;
  logic                first_q;
  logic                err_q;

  logic accept_c;
  logic busy_c;
  logic run_c;
  logic issue_c;
  logic accum_c;

  // Decode of registered state; stall gates the enables in the same cycle.
  always_comb begin
    accept_c = (state == S_IDLE) && bus.start && (bus.len != '0);
    busy_c   = (state == S_CLEAR) || (state == S_FEED) || (state == S_DRAIN);
    run_c    = ((state == S_FEED) || (state == S_DRAIN)) && !bus.stall;
    issue_c  = (state == S_FEED) && !bus.stall;
    accum_c  = run_c && pipe[MULT_LAT-1];
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept_c) state_nx = S_CLEAR;
      S_CLEAR: state_nx = S_FEED;
      S_FEED:  if (issue_c && (issue_cnt == len_q - ONE)) state_nx = S_DRAIN;
      S_DRAIN: if (run_c && (drain_cnt == DRAIN_LAST)) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Job length, issue/drain counters, issue pipeline and first-term flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q     <= '0;
      issue_cnt <= '0;
      drain_cnt <= '0;
      pipe      <= '0;
      first_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      err_q <= (state == S_IDLE) && bus.start && (bus.len == '0);
      if (accept_c) len_q <= bus.len;
      if (state == S_CLEAR) begin
        issue_cnt <= '0;
        drain_cnt <= '0;
        pipe      <= '0;
        first_q   <= 1'b1;
      end else begin
        if (issue_c) issue_cnt <= issue_cnt + ONE;
        if (run_c && (state == S_DRAIN)) drain_cnt <= drain_cnt + ONE;
        // Stalled cycles freeze the pipeline so issued terms are never lost.
        if (run_c) pipe <= MULT_LAT'({pipe, issue_c});
        if (accum_c) first_q <= 1'b0;
      end
    end
  end

`ifdef MAC_CTRL_PERF_CNT_EN
  logic [31:0] perf_q;

  // Saturating job cycle counter; holds its final value while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             perf_q <= '0;
    else if (accept_c)                   perf_q <= '0;
    else if (busy_c && (perf_q != '1))   perf_q <= perf_q + 32'd1;
  end

  assign bus.perf_cycles = perf_q;
`else
  assign bus.perf_cycles = '0;
`endif

  assign bus.busy        = busy_c;
  assign bus.done        = (state == S_DONE);
  assign bus.start_err   = err_q;
  assign bus.feed_req    = issue_c;
  assign bus.en_mult     = issue_c;
  assign bus.clr_mult    = (state == S_CLEAR);
  assign bus.clr_accum   = (state == S_CLEAR);
  assign bus.en_accum    = accum_c;
  assign bus.accum_start = accum_c && first_q;

endmodule

// File: tb/tb_mac_ctrl.sv
// tb_mac_ctrl: scoreboard bench for two mac_ctrl instances (L=1/A=1 and
// L=3/A=2) sharing one random stimulus stream. A timeline model fills the
// scoreboard with expected output events when each start is issued.
module tb_mac_ctrl;
  localparam int unsigned LEN_W = 16;
  localparam int NCYC      = 6000;
  localparam int FREE_END  = 400;
  localparam int RAND_FROM = 600;
  localparam int RAND_TO   = 4500;
  localparam int L0 = 1, A0 = 1, L1 = 3, A1 = 2;

  localparam int K_CLR = 0, K_FEED = 1, K_ACC = 2, K_DONE = 3;
  localparam int K_ERR = 4, K_RISE = 5, K_FALL = 6;

  typedef struct {
    int key;
    int val;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mac_ctrl_if #(.LEN_W(LEN_W)) bus0 ();
  mac_ctrl_if #(.LEN_W(LEN_W)) bus1 ();

  mac_ctrl #(.LEN_W(LEN_W), .MULT_LAT(L0), .ACC_LAT(A0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0));
  mac_ctrl #(.LEN_W(LEN_W), .MULT_LAT(L1), .ACC_LAT(A1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1));

  ev_t  sb[$];
  bit   stall_pat [NCYC];
  int   next_free [2];
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;
  bit   running  = 1'b0;

  logic [6:0] m_pres [2];
  int         m_val  [2][7];
  logic       prev_busy [2];

  function automatic string kname(int k);
    case (k)
      K_CLR:   return "clear";
      K_FEED:  return "feed";
      K_ACC:   return "accum";
      K_DONE:  return "done_perf";
      K_ERR:   return "start_err";
      K_RISE:  return "busy_rise";
      default: return "busy_fall";
    endcase
  endfunction

  function automatic bit stall_at(int t);
    return (t < NCYC) ? stall_pat[t] : 1'b0;
  endfunction

  function automatic void push(int c, int inst, int kind, int val);
    ev_t e;
    int  i;
    e.key = c * 16 + inst * 8 + kind;
    e.val = val;
    i = 0;
    while (i < sb.size() && sb[i].key <= e.key) i++;
    sb.insert(i, e);
  endfunction

  // Timeline model: after CLEAR, the n-th non-stalled cycle issues operand n
  // (n<K), accumulates term n-L (L<=n<K+L); K+L+A such cycles precede DONE.
  function automatic void predict(int inst, int c, int k);
    int lm, am, t, n, perf;
    lm = (inst == 0) ? L0 : L1;
    am = (inst == 0) ? A0 : A1;
    if (c < next_free[inst]) return;
    if (k == 0) begin
      push(c + 1, inst, K_ERR, 1);
      return;
    end
    push(c + 1, inst, K_CLR, 3);
    push(c + 1, inst, K_RISE, 1);
    t = c + 2;
    n = 0;
    while (n < k + lm + am) begin
      if (!stall_at(t)) begin
        if (n < k) push(t, inst, K_FEED, 3);
        if (n >= lm && n < k + lm) push(t, inst, K_ACC, (n == lm) ? 3 : 2);
        n++;
      end
      t++;
    end
`ifdef MAC_CTRL_PERF_CNT_EN
    perf = t - (c + 1);
`else
    perf = 0;
`endif
    push(t, inst, K_DONE, perf);
    push(t, inst, K_FALL, 1);
    next_free[inst] = t + 1;
  endfunction

  task automatic check(string name, longint act, longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  function automatic void grab(int i, logic busy, logic done, logic err,
                               logic feed, logic mult, logic clrm, logic clra,
                               logic acc, logic accs, logic [31:0] perf);
    m_pres[i][K_CLR]  = clrm | clra;  m_val[i][K_CLR]  = int'({clrm, clra});
    m_pres[i][K_FEED] = feed | mult;  m_val[i][K_FEED] = int'({feed, mult});
    m_pres[i][K_ACC]  = acc | accs;   m_val[i][K_ACC]  = int'({acc, accs});
    m_pres[i][K_DONE] = done;         m_val[i][K_DONE] = int'(perf);
    m_pres[i][K_ERR]  = err;          m_val[i][K_ERR]  = 1;
    m_pres[i][K_RISE] = busy & ~prev_busy[i]; m_val[i][K_RISE] = 1;
    m_pres[i][K_FALL] = ~busy & prev_busy[i]; m_val[i][K_FALL] = 1;
    prev_busy[i] = busy;
  endfunction

  // Monitor: every observed output event must match the scoreboard head.
  always @(negedge clk) begin
    if (rst || !running) begin
      prev_busy[0] = 1'b0;
      prev_busy[1] = 1'b0;
    end else begin
      grab(0, bus0.busy, bus0.done, bus0.start_err, bus0.feed_req, bus0.en_mult,
           bus0.clr_mult, bus0.clr_accum, bus0.en_accum, bus0.accum_start,
           bus0.perf_cycles);
      grab(1, bus1.busy, bus1.done, bus1.start_err, bus1.feed_req, bus1.en_mult,
           bus1.clr_mult, bus1.clr_accum, bus1.en_accum, bus1.accum_start,
           bus1.perf_cycles);
      while (sb.size() > 0 && sb[0].key < cyc * 16) begin
        checks++; failures++;
        $display("FAIL missed %s inst%0d at cyc %0d (now %0d)",
                 kname(sb[0].key % 8), (sb[0].key / 8) % 2, sb[0].key / 16, cyc);
        void'(sb.pop_front());
      end
      for (int i = 0; i < 2; i++) begin
        for (int k = 0; k < 7; k++) begin
          if (m_pres[i][k]) begin
            checks++;
            if (sb.size() > 0 && sb[0].key == cyc * 16 + i * 8 + k) begin
              if (sb[0].val != m_val[i][k]) begin
                failures++;
                $display("FAIL %s inst%0d cyc=%0d got=%0d required=%0d",
                         kname(k), i, cyc, m_val[i][k], sb[0].val);
              end
              void'(sb.pop_front());
            end else begin
              failures++;
              $display("FAIL unexpected %s inst%0d cyc=%0d got=%0d required=none",
                       kname(k), i, cyc, m_val[i][k]);
            end
          end
        end
      end
      while (sb.size() > 0 && sb[0].key < (cyc + 1) * 16) begin
        checks++; failures++;
        $display("FAIL missed %s inst%0d at cyc %0d got=absent required=present",
                 kname(sb[0].key % 8), (sb[0].key / 8) % 2, cyc);
        void'(sb.pop_front());
      end
    end
  end

  task automatic step(bit s, int k);
    @(posedge clk);
    cyc++;
    #1;
    bus0.start = s;          bus1.start = s;
    bus0.len   = LEN_W'(k);  bus1.len   = LEN_W'(k);
    bus0.stall = stall_at(cyc);
    bus1.stall = stall_at(cyc);
    if (s) begin
      predict(0, cyc, k);
      predict(1, cyc, k);
    end
  endtask

  task automatic launch(int c, int k);
    while (cyc < c - 1) step(1'b0, 0);
    step(1'b1, k);
  endtask

  task automatic check_quiet(string tag);
    check({tag, "_outs0"}, longint'({bus0.busy, bus0.done, bus0.start_err,
          bus0.feed_req, bus0.en_mult, bus0.clr_mult, bus0.en_accum,
          bus0.clr_accum, bus0.accum_start, bus0.perf_cycles}), 0);
    check({tag, "_outs1"}, longint'({bus1.busy, bus1.done, bus1.start_err,
          bus1.feed_req, bus1.en_mult, bus1.clr_mult, bus1.en_accum,
          bus1.clr_accum, bus1.accum_start, bus1.perf_cycles}), 0);
  endtask

  initial begin
    bus0.start = 1'b0; bus0.len = '0; bus0.stall = 1'b0;
    bus1.start = 1'b0; bus1.len = '0; bus1.stall = 1'b0;
    next_free[0] = 0;
    next_free[1] = 0;
    for (int t = 0; t < NCYC; t++)
      stall_pat[t] = (t >= FREE_END) && ($urandom_range(0, 3) == 0);
    stall_pat[43] = 1'b1;
    stall_pat[44] = 1'b1;

    #1 rst = 1'b1;
    #1 check_quiet("reset");
    step(1'b0, 0);
    step(1'b0, 0);
    #2 rst = 1'b0;
    running = 1'b1;

    launch(10, 4);           // basic length-4 job
    launch(40, 4);           // same job, stall in cycles 43-44
    launch(70, 0);           // zero length -> start_err only
    launch(90, 3);           // length 3 ...
    launch(93, 5);           // ... start during FEED is ignored
    launch(120, 1);          // single term
    launch(150, 8);          // length 8, reset lands in FEED

    while (cyc < 154) step(1'b0, 0);
    #2 rst = 1'b1;
    sb.delete();
    next_free[0] = 0;
    next_free[1] = 0;
    #1 check_quiet("midjob_rst");
    step(1'b0, 0);
    step(1'b0, 0);
    step(1'b0, 0);
    #2 rst = 1'b0;

    launch(170, 2);          // job after reset completes normally
    launch(200, 300);        // long job running into the stalled region

    while (cyc < RAND_FROM) step(1'b0, 0);
    while (cyc < RAND_TO) begin
      if ($urandom_range(0, 7) == 0) step(1'b1, int'($urandom_range(0, 12)));
      else                           step(1'b0, 0);
    end
    repeat (80) step(1'b0, 0);
    @(negedge clk);
    #1;
    check("scoreboard_drained", longint'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mac_ctrl.md
# mac_ctrl

Sequencer for one multiply-and-accumulate processing element. Takes a job length K and a start pulse, then drives the PE's multiplier and accumulator enable, clear and start controls so that exactly K operand pairs are multiplied and summed. Also requests operands from the upstream feeder and signals completion. One `mac_ctrl` sits beside each PE row (or array) in the systolic matrix-multiply datapath.

## Interface
- `LEN_W`, 16: width of the job-length input. Maximum K is 2^LEN_W−1.
- `MULT_LAT`, 1: cycles from `en_mult` to a valid multiplier result (≥1).
- `ACC_LAT`, 1: cycles from the last `en_accum` to a valid accumulator output (≥1).
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: job request, sampled in IDLE only.
- `len` input LEN_W: job length K, sampled with `start`.
- `stall` input 1: freezes all progress while high.
- `busy` output 1: job in progress (CLEAR/FEED/DRAIN).
- `done` output 1: one-cycle pulse; PE result valid this cycle.
- `start_err` output 1: one-cycle pulse; `start` sampled with `len`=0.
- `feed_req` output 1: upstream must present an a/b pair this cycle.
- `en_mult` output 1: multiplier enable.
- `clr_mult` output 1: multiplier clear.
- `en_accum` output 1: accumulator enable.
- `clr_accum` output 1: accumulator clear.
- `accum_start` output 1: marks the first accumulated term of a job.
- `perf_cycles` output 32: job cycle count (see Configuration).

## Operation
- States: IDLE, CLEAR, FEED, DRAIN, DONE.
- IDLE:
  - `start` with `len`≠0 → latch `len`, go to CLEAR.
  - `start` with `len`=0 → pulse `start_err`, stay in IDLE.
  - `start` in any other state is ignored.
- CLEAR: one cycle. `clr_mult`=`clr_accum`=1, then → FEED. `stall` has no effect in CLEAR.
- FEED: in each non-stalled cycle, `feed_req`=`en_mult`=1 and the issue counter increments. After the K-th issue → DRAIN.
- Issue pipeline: a MULT_LAT-deep shift register of issue bits.
  - Its output drives `en_accum`.
  - `accum_start`=`en_accum` AND first-term flag. The flag is set in CLEAR and cleared after the first `en_accum`.
- DRAIN: counter of MULT_LAT+ACC_LAT non-stalled cycles, then → DONE.
- DONE: one cycle, `done`=1, → IDLE. `stall` is ignored in DONE.
- Stall (FEED/DRAIN):
  - Every enable output is 0.
  - Shift register, issue counter and drain counter all hold.
  - PE contract: mult and accum hold state when their enable is low.
- Counters are LEN_W wide and compared against the latched length. There is no wrap; K=2^LEN_W−1 must complete.
- Reset mid-job: the FSM goes to IDLE immediately. The shift register, counters and flags clear. No `done` pulse is issued.

## Timing
- Reset values: every output is 0, including `perf_cycles`. State is IDLE.
- `start` sampled at cycle 0, no stalls, length K, MULT_LAT L, ACC_LAT A:
  - CLEAR at cycle 1.
  - FEED cycles 2..K+1.
  - `en_accum` cycles 2+L..K+1+L.
  - `accum_start` at cycle 2+L.
  - DRAIN cycles K+2..K+1+L+A.
  - `done` at cycle K+2+L+A.
- Each stalled cycle in FEED/DRAIN adds exactly one cycle to the timeline.
- `busy` is high from cycle 1 through K+1+L+A. It is low in DONE.
- A new `start` is accepted in the cycle after `done` at the earliest.
- All outputs are registered or decoded from registered state. There are no combinational input→output paths, except that `stall` gates the enable outputs in the same cycle.

## Configuration
- `MAC_CTRL_PERF_CNT_EN`:
  - Defined: a 32-bit counter clears on entry to CLEAR and increments every cycle in CLEAR/FEED/DRAIN, stalled cycles included. It saturates at 0xFFFF_FFFF. `perf_cycles` holds the final value from `done` until the next CLEAR.
  - Undefined: no counter logic is built; `perf_cycles` is tied to 0.

## Test plan
- Length 4, L=1, A=1, no stall, `start` at cycle 0:
  - `clr_*` at cycle 1.
  - `en_mult` cycles 2–5; `en_accum` cycles 3–6.
  - `accum_start` only at cycle 3.
  - `done` at cycle 8; `perf_cycles`=7 with the macro defined.
- Same job with `stall` high in cycles 3–4:
  - `en_mult` at cycles 2, 5, 6, 7 (no enables in cycles 3–4).
  - `done` at cycle 10.
  - Exactly 4 `en_mult` and 4 `en_accum` pulses.
- `start` with `len`=0 → `start_err` pulse one cycle later; `busy` stays 0; no enables.
- `start` asserted during FEED of a length-3 job → ignored; one `done` only; pulse counts are 3/3.
- `rst` asserted asynchronously in FEED of a length-8 job:
  - All outputs are 0 immediately; no `done`.
  - A following length-2 job completes normally.
- Length 1 with L=3, A=2 → one `en_mult` at cycle 2; `en_accum` with `accum_start` at cycle 5; `done` at cycle 8.
